// File: rtl/operand_demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : operand_demux_pkg
//  Purpose  : Shared operand width and destination-select codes for the
//             operand multiplexer / demultiplexer pair.
//  Revision : 1.0 - initial release
// ============================================================================
package operand_demux_pkg;

  localparam int OPERAND_SIZE = 8;

  localparam logic [1:0] c_SEL_DROP  = 2'b00;
  localparam logic [1:0] c_SEL_PORT1 = 2'b01;
  localparam logic [1:0] c_SEL_PORT2 = 2'b10;
  localparam logic [1:0] c_SEL_BCAST = 2'b11;

  // True when the select code routes an operand to destination 1.
  function automatic logic targets_port1(input logic [1:0] s);
    return (s == c_SEL_PORT1) || (s == c_SEL_BCAST);
  endfunction

  // True when the select code routes an operand to destination 2.
  function automatic logic targets_port2(input logic [1:0] s);
    return (s == c_SEL_PORT2) || (s == c_SEL_BCAST);
  endfunction

endpackage
`default_nettype wire

// File: rtl/operand_demux_slot.sv
`default_nettype none
// ============================================================================
//  Module   : demux_slot
//  Purpose  : One-entry output register with valid/ready handshake. Accepts
//             a load in the same cycle as the held operand is consumed.
//  Revision : 1.0 - initial release
// ============================================================================
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_free
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Slot can take a new operand when empty or being drained this cycle.
  // While reset is asserted the slot reports free, since it is about to be emptied.
  assign o_free  = !rst_n || !r_valid || i_ready;
  assign o_data  = r_data;
  assign o_valid = r_valid;

  // Load has priority over consume so a simultaneous drain+reload keeps valid high.
  // Data is only written on load, so it holds after valid drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_din;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/operand_demux.sv
`default_nettype none
// ============================================================================
//  Module   : operand_demux
//  Purpose  : Routes an operand to one of two registered destinations, to
//             both (all-or-nothing broadcast), or drops it while counting.
//  Revision : 1.0 - initial release
// ============================================================================
module operand_demux
  import operand_demux_pkg::*;
#(
  parameter int WIDTH = OPERAND_SIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic             out1_valid,
  output logic             out2_valid,
  input  logic             out1_ready,
  input  logic             out2_ready,
  output logic [7:0]       drop_cnt
);

  logic       w_free1;
  logic       w_free2;
  logic       w_accept;
  logic       w_load1;
  logic       w_load2;
  logic [7:0] r_drop_cnt;

  // Ready depends only on the slots the select code targets; broadcast
  // needs both so a transfer never lands in just one of them.
  always_comb begin
    in_ready = 1'b0;
    case (sel)
      c_SEL_DROP:  in_ready = 1'b1;
      c_SEL_PORT1: in_ready = w_free1;
      c_SEL_PORT2: in_ready = w_free2;
      c_SEL_BCAST: in_ready = w_free1 && w_free2;
      default:     in_ready = 1'b0;
    endcase
  end

  assign w_accept = in_valid && in_ready;
  assign w_load1  = w_accept && targets_port1(sel);
  assign w_load2  = w_accept && targets_port2(sel);

  demux_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load1),
    .i_din   (din),
    .i_ready (out1_ready),
    .o_data  (out1),
    .o_valid (out1_valid),
    .o_free  (w_free1)
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load2),
    .i_din   (din),
    .i_ready (out2_ready),
    .o_data  (out2),
    .o_valid (out2_valid),
    .o_free  (w_free2)
  );

  // Count accepted drop transfers; wraps naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop_cnt <= 8'd0;
    end else if (w_accept && (sel == c_SEL_DROP)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_operand_demux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_demux
//  Purpose  : Self-checking bench for operand_demux (WIDTH=8): directed
//             scenarios followed by random traffic against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_operand_demux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sel;
  logic [7:0] din;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out1, out2;
  logic       out1_valid, out2_valid;
  logic       out1_ready, out2_ready;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: what each destination holds and the drop count.
  logic       m_v1 = 1'b0, m_v2 = 1'b0;
  logic [7:0] m_d1 = 8'h00, m_d2 = 8'h00;
  int         m_drops = 0;

  always #5 clk = ~clk;

  operand_demux #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel        (sel),
    .din        (din),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out1       (out1),
    .out2       (out2),
    .out1_valid (out1_valid),
    .out2_valid (out2_valid),
    .out1_ready (out1_ready),
    .out2_ready (out2_ready),
    .drop_cnt   (drop_cnt)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check ready, advance model and DUT, check outputs.
  task automatic cyc(input logic [1:0] s, input logic [7:0] d, input logic v,
                     input logic r1, input logic r2, input logic rn);
    logic free1, free2, exp_rdy, acc, to1, to2;
    sel = s; din = d; in_valid = v; out1_ready = r1; out2_ready = r2; rst_n = rn;
    #1;
    free1 = !rn || !m_v1 || r1;
    free2 = !rn || !m_v2 || r2;
    to1   = (s == 2'd1) || (s == 2'd3);
    to2   = (s == 2'd2) || (s == 2'd3);
    exp_rdy = (!to1 || free1) && (!to2 || free2);
    chk("in_ready", {7'd0, in_ready}, {7'd0, exp_rdy});
    acc = v && exp_rdy;
    @(posedge clk);
    if (!rn) begin
      m_v1 = 0; m_v2 = 0; m_d1 = 0; m_d2 = 0; m_drops = 0;
    end else begin
      if (acc && to1) begin m_d1 = d; m_v1 = 1; end
      else if (m_v1 && r1) m_v1 = 0;
      if (acc && to2) begin m_d2 = d; m_v2 = 1; end
      else if (m_v2 && r2) m_v2 = 0;
      if (acc && s == 2'd0) m_drops = (m_drops + 1) % 256;
    end
    #1;
    chk("out1_valid", {7'd0, out1_valid}, {7'd0, m_v1});
    chk("out2_valid", {7'd0, out2_valid}, {7'd0, m_v2});
    chk("out1", out1, m_d1);
    chk("out2", out2, m_d2);
    chk("drop_cnt", drop_cnt, m_drops[7:0]);
  endtask

  initial begin
    logic [7:0] held;
    rst_n = 0; sel = 0; din = 0; in_valid = 0; out1_ready = 0; out2_ready = 0;

    // Reset
    cyc(2'd3, 8'hAA, 1, 0, 0, 0);
    cyc(2'd1, 8'h11, 1, 0, 0, 0);
    chk("reset_out1_valid", {7'd0, out1_valid}, 8'd0);
    chk("reset_drop_cnt", drop_cnt, 8'd0);

    // Single port-1 transfer, consumed immediately
    cyc(2'd1, 8'h5A, 1, 1, 1, 1);
    chk("p1_data", out1, 8'h5A);
    chk("p1_valid", {7'd0, out1_valid}, 8'd1);
    cyc(2'd0, 8'h00, 0, 1, 1, 1);
    chk("p1_valid_drop", {7'd0, out1_valid}, 8'd0);
    chk("p2_valid_idle", {7'd0, out2_valid}, 8'd0);

    // Broadcast with port 2 stalled, then second broadcast waits for it
    cyc(2'd3, 8'hC3, 1, 0, 0, 1);
    chk("bc_out2", out2, 8'hC3);
    cyc(2'd0, 8'h00, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) cyc(2'd3, 8'h3C, 1, 1, 0, 1);
    cyc(2'd3, 8'h3C, 1, 1, 1, 1);
    chk("bc2_out1", out1, 8'h3C);
    chk("bc2_out2", out2, 8'h3C);
    cyc(2'd0, 8'h00, 0, 1, 1, 1);

    // Back-to-back port-2 at full throughput
    cyc(2'd2, 8'h01, 1, 1, 1, 1);
    chk("b2b_1", out2, 8'h01);
    cyc(2'd2, 8'h02, 1, 1, 1, 1);
    chk("b2b_2", out2, 8'h02);
    cyc(2'd2, 8'h03, 1, 1, 1, 1);
    chk("b2b_3", out2, 8'h03);
    cyc(2'd0, 8'h00, 0, 1, 1, 1);

    // 257 drops wrap the counter to 1
    for (int i = 0; i < 257; i++) cyc(2'd0, 8'(i), 1, 1, 1, 1);
    chk("drop_wrap", drop_cnt, 8'd1);

    // Stall port 1 with toggling din
    cyc(2'd1, 8'h77, 1, 0, 0, 1);
    held = out1;
    for (int i = 0; i < 5; i++) cyc(2'd1, (i[0] ? 8'hFF : 8'h00), 1, 0, 0, 1);
    chk("stall_hold", out1, held);

    // Reset mid-transfer discards the held operand
    cyc(2'd0, 8'h00, 0, 0, 0, 0);
    chk("rst_mid_out1", out1, 8'h00);
    chk("rst_mid_valid", {7'd0, out1_valid}, 8'd0);

    // Random traffic, including occasional resets
    for (int i = 0; i < 600; i++)
      cyc(2'($urandom_range(0, 3)), 8'($urandom), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 63) != 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
